seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_adder_pkg.sv | 13 +
 rtl/chunk_adder.sv | 40 ++++
 rtl/seq_chunk_adder.sv | 108 ++++++++++
 tb/tb_seq_chunk_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and mode constants.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from single-bit full adders;
// also exposes the carry into the MSB so the caller can derive signed overflow.
module one_bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    one_bit_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, publishing
// result/cout/ovf only on completion. busy is high in RUN, done pulses in DONE.
// Handshake: start is accepted on a rising edge only when busy=0 (IDLE or DONE);
// done is a one-cycle pulse, and result/cout/ovf hold until the next done.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output state_e           state_dbg
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;  // already holds ~b for subtraction
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] next_partial;
  logic [CHUNK-1:0] sum;
  logic             co;
  logic             c_msb;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[int'(idx)*CHUNK +: CHUNK]),
    .b     (b_q[int'(idx)*CHUNK +: CHUNK]),
    .ci    (carry),
    .sum   (sum),
    .co    (co),
    .c_msb (c_msb)
  );

  always_comb begin
    next_partial = partial;
    next_partial[int'(idx)*CHUNK +: CHUNK] = sum;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      partial <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= (mode == MODE_SUB) ? ~b : b;
            carry   <= (mode == MODE_SUB);
            idx     <= '0;
            partial <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          partial <= next_partial;
          carry   <= co;
          if (idx == LAST_IDX) begin
            // The final chunk holds the word MSB, so its carries give cout/ovf.
            result <= next_partial;
            cout   <= co;
            ovf    <= c_msb ^ co;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 16/4 instance and an 8/8 instance,
// with expected results queued at issue time and checked by monitors on done.
module tb_seq_chunk_adder;
  import seq_adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // 16-bit / 4-bit chunk instance
  logic        start16, mode16;
  logic [15:0] a16, b16, result16;
  logic        cout16, ovf16, busy16, done16;
  state_e      dbg16;

  // 8-bit single-chunk instance
  logic        start8, mode8;
  logic [7:0]  a8, b8, result8;
  logic        cout8, ovf8, busy8, done8;
  state_e      dbg8;

  logic [17:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [9:0]  exp8_q[$];
  int          exp8_cyc_q[$];

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .result(result16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16),
    .state_dbg(dbg16)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .result(result8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8),
    .state_dbg(dbg8)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitors: pop expected response whenever done is seen
  always @(negedge clk) begin
    if (!rst && done16 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done16: got done=1 expected no operation pending (cycle %0d)", cyc);
      end else begin
        logic [17:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("result16", 32'(result16), 32'(e[17:2]));
        chk("cout16", 32'(cout16), 32'(e[1]));
        chk("ovf16", 32'(ovf16), 32'(e[0]));
        chk("done_cycle16", cyc, ec);
        chk("busy_at_done16", 32'(busy16), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done8: got done=1 expected no operation pending (cycle %0d)", cyc);
      end else begin
        logic [9:0] e;
        int ec;
        e  = exp8_q.pop_front();
        ec = exp8_cyc_q.pop_front();
        chk("result8", 32'(result8), 32'(e[9:2]));
        chk("cout8", 32'(cout8), 32'(e[1]));
        chk("ovf8", 32'(ovf8), 32'(e[0]));
        chk("done_cycle8", cyc, ec);
      end
    end
  end

  // driver: drives one start pulse; returns at the negedge after acceptance
  task automatic issue16(input logic m, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic ec, input logic ev, input bit push);
    @(negedge clk);
    start16 = 1'b1; mode16 = m; a16 = av; b16 = bv;
    if (push) begin
      exp_q.push_back({er, ec, ev});
      exp_cyc_q.push_back(cyc + 1 + 4);
    end
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic drain16();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain16_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic drain8();
    int k = 0;
    while (exp8_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain8_pending", exp8_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    chk("reset_result", 32'(result16), 32'd0);
    chk("reset_flags", {29'd0, cout16, ovf16, done16}, 32'd0);
    chk("reset_busy", 32'(busy16), 32'd0);
    chk("reset_state", 32'(dbg16), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_release", 32'(dbg16), 32'(IDLE));

    // add FFFF+0001 with busy-window check
    issue16(MODE_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", 32'(busy16), 32'd1);
      @(negedge clk);
    end
    chk("busy_done_cycle", 32'(busy16), 32'd0);
    chk("done_pulse", 32'(done16), 32'd1);
    drain16();
    chk("done_one_cycle", 32'(done16), 32'd0);

    issue16(MODE_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
    drain16();
    issue16(MODE_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    drain16();
    issue16(MODE_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    drain16();
    for (int i = 0; i < 3; i++) begin
      chk("result_hold", 32'(result16), 32'hFFFE);
      chk("state_idle_hold", 32'(dbg16), 32'(IDLE));
      @(negedge clk);
    end

    // start re-asserted in RUN cycle 2 must be ignored
    issue16(MODE_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start16 = 1'b1; mode16 = MODE_SUB; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    start16 = 1'b0;
    drain16();

    // start held through DONE: back-to-back operation, no idle cycle
    issue16(MODE_SUB, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start16 = 1'b1; mode16 = MODE_ADD; a16 = 16'h4000; b16 = 16'h4000;
    @(negedge clk);
    chk("done_before_b2b", 32'(done16), 32'd1);
    exp_q.push_back({16'h8000, 1'b0, 1'b1});
    exp_cyc_q.push_back(cyc + 1 + 4);
    @(negedge clk);
    start16 = 1'b0;
    chk("b2b_busy_no_bubble", 32'(busy16), 32'd1);
    drain16();

    // reset in RUN cycle 2 abandons the operation
    issue16(MODE_ADD, 16'hAAAA, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_result", 32'(result16), 32'd0);
    chk("async_rst_flags", {29'd0, cout16, ovf16, done16}, 32'd0);
    chk("async_rst_busy", 32'(busy16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(dbg16), 32'(IDLE));
      chk("post_rst_result", 32'(result16), 32'd0);
    end

    issue16(MODE_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
    drain16();

    // single-chunk instance: done one edge after acceptance
    @(negedge clk);
    start8 = 1'b1; mode8 = MODE_ADD; a8 = 8'h80; b8 = 8'h80;
    exp8_q.push_back({8'h00, 1'b1, 1'b1});
    exp8_cyc_q.push_back(cyc + 1 + 1);
    @(negedge clk);
    start8 = 1'b0;
    drain8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
